multicore_result_collector: RTL and testbench

//  Receiving end of the Jimmy cores' strobed output ports. Per core it issues the start address and captures the result

---
 rtl/jimmy_pkg.sv | 22 ++
 rtl/multicore_result_collector_strobe_capture.sv | 60 ++++++
 rtl/multicore_result_collector.sv | 113 +++++++++++
 tb/tb_multicore_result_collector.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/jimmy_pkg.sv
// Shared constants and FSM encoding for the Jimmy multicore result collector.
package jimmy_pkg;

    localparam int NUM_CORES   = 4;
    localparam int DATA_W      = 8;
    localparam int CNT_W       = 32;
    localparam int STROBE_BIT  = 3;
    localparam int ADDR_STRIDE = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } run_state_e;

    // Unwrapped start address of a core; the caller truncates to its bus width.
    function automatic int unsigned core_start_addr(input int unsigned idx,
                                                    input int unsigned stride);
        return idx * stride;
    endfunction

endpackage

// File: rtl/multicore_result_collector_strobe_capture.sv
// Per-core result capture: latches the result bus value seen at the last
// clock where the qualifying strobe bit was high, once that strobe falls.
module strobe_capture #(
    parameter int DATA_W     = jimmy_pkg::DATA_W,
    parameter int STROBE_BIT = jimmy_pkg::STROBE_BIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [3:0]        strobe,
    input  logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] core_result,
    output logic              result_valid
);

    logic              strobe_q, strobe_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic              valid_q, valid_d;
    logic              fall;
    logic              unused_strobe_bits;

    // Only one strobe bit qualifies a result write; the rest are ignored.
    assign unused_strobe_bits = ^strobe;

    // Edge detect against the previous sample; clear overrides a coincident edge.
    always_comb begin
        strobe_d = strobe[STROBE_BIT];
        res_d    = result;
        fall     = strobe_q & ~strobe[STROBE_BIT];
        cap_d    = cap_q;
        valid_d  = valid_q;
        if (clear) begin
            cap_d   = '0;
            valid_d = 1'b0;
        end else if (fall) begin
            cap_d   = res_q;
            valid_d = 1'b1;
        end
    end

    // History and captured result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            strobe_q <= 1'b0;
            res_q    <= '0;
            cap_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            strobe_q <= strobe_d;
            res_q    <= res_d;
            cap_q    <= cap_d;
            valid_q  <= valid_d;
        end
    end

    assign core_result  = cap_q;
    assign result_valid = valid_q;

endmodule

// File: rtl/multicore_result_collector.sv
// Collects strobed results from the Jimmy cores, sums them and times the run
// until every core reports complete.
module multicore_result_collector #(
    parameter int NUM_CORES   = jimmy_pkg::NUM_CORES,
    parameter int DATA_W      = jimmy_pkg::DATA_W,
    parameter int CNT_W       = jimmy_pkg::CNT_W,
    parameter int STROBE_BIT  = jimmy_pkg::STROBE_BIT,
    parameter int ADDR_STRIDE = jimmy_pkg::ADDR_STRIDE
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic [4*NUM_CORES-1:0]      out_strobe_flat,
    input  logic [DATA_W*NUM_CORES-1:0] result_flat,
    input  logic [NUM_CORES-1:0]        complete_flat,
    output logic [DATA_W*NUM_CORES-1:0] start_addr_flat,
    output logic [DATA_W*NUM_CORES-1:0] core_result,
    output logic [NUM_CORES-1:0]        result_valid,
    output logic [DATA_W+1:0]           total,
    output logic                        all_done,
    output logic [CNT_W-1:0]            cycle_count,
    output logic                        cnt_sat
);

    import jimmy_pkg::*;

    run_state_e         state_q;
    logic [CNT_W-1:0]   cycle_count_q;
    logic               cnt_sat_q;
    logic               all_done_q;
    logic [DATA_W+1:0]  total_q, total_d;

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
        assign start_addr_flat[DATA_W*i +: DATA_W] =
            DATA_W'(core_start_addr(i, ADDR_STRIDE));

        strobe_capture #(
            .DATA_W     (DATA_W),
            .STROBE_BIT (STROBE_BIT)
        ) u_capture (
            .clk          (clk),
            .reset        (reset),
            .clear        (clear),
            .strobe       (out_strobe_flat[4*i +: 4]),
            .result       (result_flat[DATA_W*i +: DATA_W]),
            .core_result  (core_result[DATA_W*i +: DATA_W]),
            .result_valid (result_valid[i])
        );
    end

    // Sum of the captured results; two guard bits keep four full-scale values exact.
    always_comb begin
        total_d = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            total_d = total_d + {2'b00, core_result[DATA_W*i +: DATA_W]};
        end
        if (clear) begin
            total_d = '0;
        end
    end

    // Registered total, one clock behind the captured results.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            total_q <= '0;
        end else begin
            total_q <= total_d;
        end
    end

    // Run FSM with saturating cycle counter; the completing cycle is not counted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cycle_count_q <= '0;
            cnt_sat_q     <= 1'b0;
            all_done_q    <= 1'b0;
        end else if (clear) begin
            state_q       <= RUN;
            cycle_count_q <= '0;
            cnt_sat_q     <= 1'b0;
            all_done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= RUN;
                end
                RUN: begin
                    if (&complete_flat) begin
                        state_q    <= DONE;
                        all_done_q <= 1'b1;
                    end else if (&cycle_count_q) begin
                        cnt_sat_q <= 1'b1;
                    end else begin
                        cycle_count_q <= cycle_count_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign total       = total_q;
    assign all_done    = all_done_q;
    assign cycle_count = cycle_count_q;
    assign cnt_sat     = cnt_sat_q;

endmodule

// File: tb/tb_multicore_result_collector.sv
// Directed bench for multicore_result_collector: a default instance plus a
// 4-bit-counter instance sharing the same stimulus.
module tb_multicore_result_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic [15:0] out_strobe_flat;
    logic [31:0] result_flat;
    logic [3:0]  complete_flat;

    logic [31:0] start_addr_flat, core_result;
    logic [3:0]  result_valid;
    logic [9:0]  total;
    logic        all_done, cnt_sat;
    logic [31:0] cycle_count;

    logic [31:0] s_start_addr_flat, s_core_result;
    logic [3:0]  s_result_valid;
    logic [9:0]  s_total;
    logic        s_all_done, s_cnt_sat;
    logic [3:0]  s_cycle_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicore_result_collector dut (
        .clk             (clk),
        .reset           (reset),
        .clear           (clear),
        .out_strobe_flat (out_strobe_flat),
        .result_flat     (result_flat),
        .complete_flat   (complete_flat),
        .start_addr_flat (start_addr_flat),
        .core_result     (core_result),
        .result_valid    (result_valid),
        .total           (total),
        .all_done        (all_done),
        .cycle_count     (cycle_count),
        .cnt_sat         (cnt_sat)
    );

    multicore_result_collector #(.CNT_W(4)) dut_sat (
        .clk             (clk),
        .reset           (reset),
        .clear           (clear),
        .out_strobe_flat (out_strobe_flat),
        .result_flat     (result_flat),
        .complete_flat   (complete_flat),
        .start_addr_flat (s_start_addr_flat),
        .core_result     (s_core_result),
        .result_valid    (s_result_valid),
        .total           (s_total),
        .all_done        (s_all_done),
        .cycle_count     (s_cycle_count),
        .cnt_sat         (s_cnt_sat)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; clear = 1'b0;
        out_strobe_flat = '0; result_flat = '0; complete_flat = '0;
        repeat (2) tick();
        n_vec++; if (start_addr_flat !== 32'hC0804000) begin n_err++; $display("FAIL reset_start_addr: got %h want %h", start_addr_flat, 32'hC0804000); end
        n_vec++; if (core_result !== 32'd0) begin n_err++; $display("FAIL reset_core_result: got %h want 0", core_result); end
        n_vec++; if (result_valid !== 4'd0) begin n_err++; $display("FAIL reset_valid: got %b want 0", result_valid); end
        n_vec++; if (total !== 10'd0) begin n_err++; $display("FAIL reset_total: got %0d want 0", total); end
        n_vec++; if (all_done !== 1'b0 || cnt_sat !== 1'b0) begin n_err++; $display("FAIL reset_flags: got done=%b sat=%b want 0 0", all_done, cnt_sat); end
        n_vec++; if (cycle_count !== 32'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", cycle_count); end
        reset = 1'b1;
        tick();
        n_vec++; if (cycle_count !== 32'd0) begin n_err++; $display("FAIL idle_to_run: got %0d want 0", cycle_count); end
        tick();
        n_vec++; if (cycle_count !== 32'd1) begin n_err++; $display("FAIL run_first_count: got %0d want 1", cycle_count); end
        n_vec++; if (s_cycle_count !== 4'd1) begin n_err++; $display("FAIL sat_first_count: got %0d want 1", s_cycle_count); end
    endtask

    task automatic test_capture();
        result_flat[15:8] = 8'd17;
        out_strobe_flat[7:4] = 4'b1000;
        repeat (3) tick();
        n_vec++; if (core_result[15:8] !== 8'd0) begin n_err++; $display("FAIL cap_early: got %0d want 0", core_result[15:8]); end
        out_strobe_flat[7:4] = 4'b0000;
        result_flat[15:8] = 8'd200;
        tick();
        n_vec++; if (core_result !== 32'h00001100) begin n_err++; $display("FAIL cap_core1: got %h want %h", core_result, 32'h00001100); end
        n_vec++; if (result_valid !== 4'b0010) begin n_err++; $display("FAIL cap_valid: got %b want 0010", result_valid); end
        n_vec++; if (total !== 10'd0) begin n_err++; $display("FAIL cap_total_lag: got %0d want 0", total); end
        tick();
        n_vec++; if (total !== 10'd17) begin n_err++; $display("FAIL cap_total: got %0d want 17", total); end
        result_flat[15:8] = 8'd5;
        out_strobe_flat[7:4] = 4'b1000;
        tick();
        out_strobe_flat[7:4] = 4'b0000;
        tick();
        n_vec++; if (core_result[15:8] !== 8'd5 || result_valid !== 4'b0010) begin n_err++; $display("FAIL cap_overwrite: got %0d/%b want 5/0010", core_result[15:8], result_valid); end
        tick();
        n_vec++; if (total !== 10'd5) begin n_err++; $display("FAIL cap_overwrite_total: got %0d want 5", total); end
    endtask

    task automatic test_all_cores();
        result_flat = 32'hFFFFFFFF;
        out_strobe_flat = 16'h8888;
        tick();
        out_strobe_flat = 16'h7777;
        tick();
        n_vec++; if (core_result !== 32'hFFFFFFFF) begin n_err++; $display("FAIL all_core_result: got %h want ffffffff", core_result); end
        n_vec++; if (result_valid !== 4'b1111) begin n_err++; $display("FAIL all_valid: got %b want 1111", result_valid); end
        tick();
        n_vec++; if (total !== 10'd1020) begin n_err++; $display("FAIL all_total: got %0d want 1020", total); end
        out_strobe_flat = 16'h0000;
        result_flat = '0;
        tick();
    endtask

    task automatic test_clear_edge();
        result_flat[23:16] = 8'd42;
        out_strobe_flat[11:8] = 4'b1000;
        tick();
        out_strobe_flat[11:8] = 4'b0000;
        pulse_clear();
        n_vec++; if (core_result !== 32'd0 || result_valid !== 4'd0) begin n_err++; $display("FAIL clr_drop: got %h/%b want 0/0", core_result, result_valid); end
        n_vec++; if (total !== 10'd0 || all_done !== 1'b0) begin n_err++; $display("FAIL clr_total_done: got %0d/%b want 0/0", total, all_done); end
        n_vec++; if (cycle_count !== 32'd0) begin n_err++; $display("FAIL clr_count: got %0d want 0", cycle_count); end
        tick();
        n_vec++; if (cycle_count !== 32'd1) begin n_err++; $display("FAIL clr_resume: got %0d want 1", cycle_count); end
        result_flat[23:16] = 8'd99;
        out_strobe_flat[11:8] = 4'b1000;
        tick();
        out_strobe_flat[11:8] = 4'b0000;
        tick();
        n_vec++; if (core_result !== 32'h00630000 || result_valid !== 4'b0100) begin n_err++; $display("FAIL clr_next_edge: got %h/%b want 00630000/0100", core_result, result_valid); end
        n_vec++; if (cycle_count !== 32'd3) begin n_err++; $display("FAIL clr_count_run: got %0d want 3", cycle_count); end
    endtask

    task automatic test_run_timer();
        complete_flat = 4'b0001;
        pulse_clear();
        n_vec++; if (cycle_count !== 32'd0 || all_done !== 1'b0) begin n_err++; $display("FAIL tmr_start: got %0d/%b want 0/0", cycle_count, all_done); end
        for (int k = 1; k <= 500; k++) begin
            tick();
            if (k == 100) complete_flat = 4'b0011;
            if (k == 300) complete_flat = 4'b0111;
        end
        n_vec++; if (cycle_count !== 32'd500 || all_done !== 1'b0) begin n_err++; $display("FAIL tmr_pre_done: got %0d/%b want 500/0", cycle_count, all_done); end
        complete_flat = 4'b1111;
        tick();
        n_vec++; if (all_done !== 1'b1 || cycle_count !== 32'd500) begin n_err++; $display("FAIL tmr_done: got %b/%0d want 1/500", all_done, cycle_count); end
        n_vec++; if (s_cycle_count !== 4'd15 || s_cnt_sat !== 1'b1 || cnt_sat !== 1'b0) begin n_err++; $display("FAIL tmr_sat: got %0d/%b/%b want 15/1/0", s_cycle_count, s_cnt_sat, cnt_sat); end
        complete_flat = 4'b0000;
        repeat (100) tick();
        n_vec++; if (all_done !== 1'b1 || cycle_count !== 32'd500) begin n_err++; $display("FAIL tmr_frozen: got %b/%0d want 1/500", all_done, cycle_count); end
        result_flat[31:24] = 8'd7;
        out_strobe_flat[15:12] = 4'b1000;
        tick();
        out_strobe_flat[15:12] = 4'b0000;
        repeat (2) tick();
        n_vec++; if (total !== 10'd7 || all_done !== 1'b1) begin n_err++; $display("FAIL tmr_late_capture: got %0d/%b want 7/1", total, all_done); end
    endtask

    task automatic test_instant_done();
        complete_flat = 4'b1111;
        pulse_clear();
        n_vec++; if (all_done !== 1'b0 || cycle_count !== 32'd0) begin n_err++; $display("FAIL inst_run: got %b/%0d want 0/0", all_done, cycle_count); end
        tick();
        n_vec++; if (all_done !== 1'b1 || cycle_count !== 32'd0) begin n_err++; $display("FAIL inst_done: got %b/%0d want 1/0", all_done, cycle_count); end
        complete_flat = 4'b0000;
    endtask

    task automatic test_reset_midrun();
        pulse_clear();
        repeat (20) tick();
        n_vec++; if (s_cycle_count !== 4'd15 || s_cnt_sat !== 1'b1) begin n_err++; $display("FAIL mid_sat: got %0d/%b want 15/1", s_cycle_count, s_cnt_sat); end
        result_flat[7:0] = 8'd33;
        out_strobe_flat[3:0] = 4'b1000;
        tick();
        out_strobe_flat[3:0] = 4'b0000;
        repeat (2) tick();
        n_vec++; if (core_result[7:0] !== 8'd33 || total !== 10'd33) begin n_err++; $display("FAIL mid_capture: got %0d/%0d want 33/33", core_result[7:0], total); end
        #2;
        reset = 1'b0;
        #1;
        n_vec++; if (core_result !== 32'd0 || result_valid !== 4'd0 || total !== 10'd0) begin n_err++; $display("FAIL mid_rst_data: got %h/%b/%0d want 0/0/0", core_result, result_valid, total); end
        n_vec++; if (cycle_count !== 32'd0 || s_cycle_count !== 4'd0 || s_cnt_sat !== 1'b0 || all_done !== 1'b0) begin n_err++; $display("FAIL mid_rst_ctrl: got %0d/%0d/%b/%b want 0/0/0/0", cycle_count, s_cycle_count, s_cnt_sat, all_done); end
        n_vec++; if (s_start_addr_flat !== 32'hC0804000) begin n_err++; $display("FAIL mid_rst_addr: got %h want c0804000", s_start_addr_flat); end
        tick();
        reset = 1'b1;
        tick();
        n_vec++; if (s_cycle_count !== 4'd0) begin n_err++; $display("FAIL mid_restart_idle: got %0d want 0", s_cycle_count); end
        tick();
        n_vec++; if (s_cycle_count !== 4'd1 || s_cnt_sat !== 1'b0 || cycle_count !== 32'd1) begin n_err++; $display("FAIL mid_restart_run: got %0d/%b/%0d want 1/0/1", s_cycle_count, s_cnt_sat, cycle_count); end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_all_cores();
        test_clear_edge();
        test_run_timer();
        test_instant_done();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
